// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain bus, then sends ACK + 40-bit frame.
// Define DHT11_RESP_CRC_ERR_EN to add crc_err_inj, which inverts checksum bit 0 of the captured frame.
module dht11_responder #(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned RESP_DLY_US  = 30,
  parameter int unsigned ACK_US       = 80,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned BIT0_HIGH_US = 26,
  parameter int unsigned BIT1_HIGH_US = 70
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  inout  wire        data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tem_int,
  input  logic [7:0] tem_dec,
`ifdef DHT11_RESP_CRC_ERR_EN
  input  logic       crc_err_inj,
`endif
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DivRaw = CLK_FREQ_HZ / 1000000;
  localparam int unsigned DivCnt = (DivRaw > 0) ? DivRaw : 1;
  localparam int unsigned DivW   = (DivCnt > 1) ? $clog2(DivCnt) : 1;

  localparam int unsigned Max0 = (START_MIN_US > RESP_DLY_US) ? START_MIN_US : RESP_DLY_US;
  localparam int unsigned Max1 = (Max0 > ACK_US) ? Max0 : ACK_US;
  localparam int unsigned Max2 = (Max1 > BIT_LOW_US) ? Max1 : BIT_LOW_US;
  localparam int unsigned Max3 = (Max2 > BIT1_HIGH_US) ? Max2 : BIT1_HIGH_US;
  localparam int unsigned Max4 = (Max3 > BIT0_HIGH_US) ? Max3 : BIT0_HIGH_US;
  localparam int unsigned CntW = $clog2(Max4 + 2);

  typedef enum logic [2:0] {
    StIdle,
    StLowMeas,
    StRespDly,
    StAckLo,
    StAckHi,
    StBitLo,
    StBitHi,
    StEndLo
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DivW-1:0]   r_div;
  logic              w_tick;
  logic [1:0]        r_sync;
  logic              w_bus;
  logic [CntW-1:0]   r_us_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [CntW-1:0]   w_cnt_inc;
  logic [CntW-1:0]   w_target;
  logic              w_expire;
  logic [39:0]       r_shift;
  logic [39:0]       w_shift_d;
  logic [5:0]        r_bits;
  logic [5:0]        w_bits_d;
  logic              r_drive_low;
  logic              w_drive_low_d;
  logic              r_busy;
  logic              w_busy_d;
  logic              r_frame_done;
  logic              w_frame_done_d;
  logic [7:0]        w_chk;
  logic [7:0]        w_chk_tx;
  logic [39:0]       w_frame;

  assign data       = r_drive_low ? 1'b0 : 1'bz;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  assign w_tick = (r_div == DivW'(DivCnt - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Synchronizer resets to the idle (pulled-up) level so reset exit is not seen as a start.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], data};
    end
  end

  assign w_bus = r_sync[1];

  assign w_chk = hum_int + hum_dec + tem_int + tem_dec;
`ifdef DHT11_RESP_CRC_ERR_EN
  assign w_chk_tx = {w_chk[7:1], w_chk[0] ^ crc_err_inj};
`else
  assign w_chk_tx = w_chk;
`endif
  assign w_frame = {hum_int, hum_dec, tem_int, tem_dec, w_chk_tx};

  assign w_cnt_inc = r_us_cnt + 1'b1;

  always_comb begin
    w_target = '0;
    unique case (r_state)
      StRespDly:        w_target = CntW'(RESP_DLY_US);
      StAckLo, StAckHi: w_target = CntW'(ACK_US);
      StBitLo, StEndLo: w_target = CntW'(BIT_LOW_US);
      StBitHi:          w_target = r_shift[39] ? CntW'(BIT1_HIGH_US) : CntW'(BIT0_HIGH_US);
      default:          w_target = '0;
    endcase
  end

  // Expires on the tick that completes the programmed number of microseconds.
  assign w_expire = w_tick && (w_cnt_inc >= w_target);

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_us_cnt;
    w_shift_d      = r_shift;
    w_bits_d       = r_bits;
    w_frame_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_bus) begin
          w_state_d = StLowMeas;
          w_cnt_d   = '0;
        end
      end
      StLowMeas: begin
        if (w_bus) begin
          w_cnt_d = '0;
          if (r_us_cnt >= CntW'(START_MIN_US)) begin
            w_state_d = StRespDly;
            w_shift_d = w_frame;
          end else begin
            w_state_d = StIdle;
          end
        end else if (w_tick && (r_us_cnt != '1)) begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StRespDly, StAckLo, StAckHi, StBitLo, StBitHi, StEndLo: begin
        if (w_expire) begin
          w_cnt_d = '0;
          unique case (r_state)
            StRespDly: w_state_d = StAckLo;
            StAckLo:   w_state_d = StAckHi;
            StAckHi: begin
              w_state_d = StBitLo;
              w_bits_d  = '0;
            end
            StBitLo:   w_state_d = StBitHi;
            StBitHi: begin
              w_shift_d = {r_shift[38:0], 1'b0};
              w_bits_d  = r_bits + 6'd1;
              w_state_d = (r_bits == 6'd39) ? StEndLo : StBitLo;
            end
            default: begin
              w_state_d      = StIdle;
              w_frame_done_d = 1'b1;
            end
          endcase
        end else if (w_tick) begin
          w_cnt_d = w_cnt_inc;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Bus drive and busy are decoded from the next state so they change with the state register.
  always_comb begin
    w_drive_low_d = (w_state_d == StAckLo) || (w_state_d == StBitLo) || (w_state_d == StEndLo);
    w_busy_d      = (w_state_d != StIdle) && (w_state_d != StLowMeas);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_us_cnt     <= '0;
      r_shift      <= '0;
      r_bits       <= '0;
      r_drive_low  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_us_cnt     <= w_cnt_d;
      r_shift      <= w_shift_d;
      r_bits       <= w_bits_d;
      r_drive_low  <= w_drive_low_d;
      r_busy       <= w_busy_d;
      r_frame_done <= w_frame_done_d;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host model drives start pulses, a monitor decodes the bus and
// compares each frame against a scoreboard queue when frame_done pulses.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int unsigned ClkHz    = 2000000;
  localparam int unsigned CycUs    = 2;
  localparam int unsigned StartMin = 200;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = 8'h00;
  logic [7:0] hum_dec = 8'h00;
  logic [7:0] tem_int = 8'h00;
  logic [7:0] tem_dec = 8'h00;
  logic       busy;
  logic       frame_done;
`ifdef DHT11_RESP_CRC_ERR_EN
  logic       crc_err_inj = 1'b0;
`endif

  wire data_bus;
  pullup (data_bus);
  assign data_bus = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .CLK_FREQ_HZ (ClkHz),
    .START_MIN_US(StartMin)
  ) u_dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .data       (data_bus),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .tem_int    (tem_int),
    .tem_dec    (tem_dec),
`ifdef DHT11_RESP_CRC_ERR_EN
    .crc_err_inj(crc_err_inj),
`endif
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #250 clk_50m = ~clk_50m;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  int          arm_id = 0;
  int          mon_seg = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: measures every bus level after an armed host release and decodes the frame.
  int          cyc = 0;
  int          seen_arm = 0;
  bit          armed = 1'b0;
  int          seg = 0;
  int          last_edge = 0;
  int          dur = 0;
  logic        prev_bus = 1'b1;
  logic        prev_busy = 1'b0;
  logic [39:0] dec = '0;
  logic [39:0] decoded = '0;
  bit          frame_ready = 1'b0;
  logic        bitv;
  logic [39:0] exp_frame;

  always @(negedge clk_50m) begin
    cyc++;
    if (!rst_n) begin
      armed       = 1'b0;
      frame_ready = 1'b0;
      mon_seg     = 0;
      prev_busy   = 1'b0;
      seen_arm    = arm_id;
    end else begin
      if (arm_id != seen_arm) begin
        seen_arm  = arm_id;
        armed     = 1'b1;
        seg       = 0;
        mon_seg   = 0;
        last_edge = cyc;
        prev_bus  = data_bus;
        dec       = '0;
      end else if (armed && (data_bus !== prev_bus)) begin
        dur       = cyc - last_edge;
        last_edge = cyc;
        if (seg == 0) begin
          check_range("resp_dly_high", dur, 29 * CycUs, 32 * CycUs);
        end else if (seg == 1) begin
          check_range("ack_low", dur, 79 * CycUs, 81 * CycUs);
        end else if (seg == 2) begin
          check_range("ack_high", dur, 79 * CycUs, 81 * CycUs);
        end else if (seg < 83) begin
          if (((seg - 3) % 2) == 0) begin
            check_range("bit_low", dur, 49 * CycUs, 51 * CycUs);
          end else begin
            bitv = (dur > 48 * CycUs);
            dec  = {dec[38:0], bitv};
            if (bitv) check_range("bit1_high", dur, 69 * CycUs, 71 * CycUs);
            else      check_range("bit0_high", dur, 25 * CycUs, 27 * CycUs);
          end
        end else begin
          check_range("end_low", dur, 49 * CycUs, 51 * CycUs);
          check("done_at_release", {63'd0, frame_done}, 64'd1);
          decoded     = dec;
          frame_ready = 1'b1;
          armed       = 1'b0;
        end
        seg++;
        mon_seg  = seg;
        prev_bus = data_bus;
      end
      if (frame_done) begin
        done_cnt++;
        check("busy_drop_with_done", {63'd0, busy}, 64'd0);
        check("busy_before_done", {63'd0, prev_busy}, 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame_done", {63'd0, frame_done}, 64'd0);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame_complete", {63'd0, frame_ready}, 64'd1);
          check("frame_data", {24'd0, decoded}, {24'd0, exp_frame});
        end
        frame_ready = 1'b0;
      end
      prev_busy = busy;
    end
  end

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    hum_int = a;
    hum_dec = b;
    tem_int = c;
    tem_dec = d;
  endtask

  // Host start: pull low for low_us, release, optionally expect a frame.
  task automatic host_start(input int low_us, input bit expect_frame, input logic [39:0] exp);
    @(posedge clk_50m);
    host_low = 1'b1;
    repeat (low_us * CycUs) @(posedge clk_50m);
    if (expect_frame) exp_q.push_back(exp);
    host_low = 1'b0;
    arm_id++;
    // Inputs changing after capture must not alter the frame in flight.
    repeat (20 * CycUs) @(posedge clk_50m);
    set_inputs(8'hC3, 8'h3C, 8'h5A, 8'hA5);
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(posedge clk_50m);
      if (done_cnt != d0) seen = 1'b1;
    end
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    repeat (10) @(posedge clk_50m);
    #1;
    check({name, "_bus_released"}, {63'd0, data_bus}, 64'd1);
    check({name, "_busy_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #1100;
    check("reset_bus", {63'd0, data_bus}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, frame_done}, 64'd0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (20) @(posedge clk_50m);

    // Nominal frame: 0x37+0x19+0x05 = 0x55
    set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
    host_start(300, 1'b1, 40'h37_00_19_05_55);
    wait_done("nominal");

    // Short pulse must be ignored
    begin
      int  d0;
      bit  busy_seen;
      bit  drive_seen;
      d0         = done_cnt;
      busy_seen  = 1'b0;
      drive_seen = 1'b0;
      @(posedge clk_50m);
      host_low = 1'b1;
      for (int i = 0; i < 100 * CycUs; i++) begin
        @(posedge clk_50m);
        #1;
        if (busy) busy_seen = 1'b1;
      end
      host_low = 1'b0;
      for (int i = 0; i < 400 * CycUs; i++) begin
        @(posedge clk_50m);
        #1;
        if (busy) busy_seen = 1'b1;
        if (data_bus !== 1'b1) drive_seen = 1'b1;
      end
      check("short_busy", {63'd0, busy_seen}, 64'd0);
      check("short_bus_z", {63'd0, drive_seen}, 64'd0);
      check("short_no_done", 64'(done_cnt - d0), 64'd0);
    end

    // Checksum wrap: 0xFF+0x80+0x7F+0x02 = 0x200 -> 0x00
    set_inputs(8'hFF, 8'h80, 8'h7F, 8'h02);
    host_start(300, 1'b1, 40'hFF_80_7F_02_00);
    wait_done("chk_wrap");

    // Alternating pattern: 4*0xAA = 0x2A8 -> 0xA8
    set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    host_start(300, 1'b1, 40'hAA_AA_AA_AA_A8);
    wait_done("alt_bits");

    // Reset during bit 12 low phase
    begin
      bit reached;
      reached = 1'b0;
      set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
      host_start(300, 1'b0, 40'h0);
      for (int i = 0; i < 8000 && !reached; i++) begin
        @(posedge clk_50m);
        if (mon_seg == 27) reached = 1'b1;
      end
      check("reach_bit12", {63'd0, reached}, 64'd1);
      repeat (10) @(posedge clk_50m);
      #100;
      check("bit12_driven_low", {63'd0, data_bus}, 64'd0);
      rst_n = 1'b0;
      #1;
      check("rst_bus_released", {63'd0, data_bus}, 64'd1);
      check("rst_busy_clear", {63'd0, busy}, 64'd0);
      repeat (5) @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (20) @(posedge clk_50m);
    end

    // Fresh frame after reset: 0x12+0x34+0x56+0x78 = 0x114 -> 0x14
    set_inputs(8'h12, 8'h34, 8'h56, 8'h78);
    host_start(300, 1'b1, 40'h12_34_56_78_14);
    wait_done("after_reset");

`ifdef DHT11_RESP_CRC_ERR_EN
    set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
    crc_err_inj = 1'b1;
    host_start(300, 1'b1, 40'h37_00_19_05_54);
    crc_err_inj = 1'b0;
    wait_done("crc_inj");
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #45ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
